// File: rtl/burst_pkg.sv
// Shared definitions for the burst address path (request serializer and burst controller).
package burst_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 20;
  localparam int unsigned LEN_WIDTH_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF    = 1024;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_LEN  = 3'd1,
    SEND_ADDR = 3'd2,
    ACTIVE    = 3'd3,
    DONE      = 3'd4,
    ABORT     = 3'd5
  } state_t;

  // Larger of two widths, used to size the shared bit counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/burst_req_tx_if.sv
// Host request and burst controller signals of the burst request serializer.
interface burst_req_tx_if
  import burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_mode;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  burst_stop;
  logic                  burst_en;
  logic                  mode_sel;
  logic                  burst_len_out;
  logic                  addr_out;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;

  // Host / controller side.
  modport master (
    output req_valid, req_mode, req_len, req_addr, burst_stop,
    input  req_ready, burst_en, mode_sel, burst_len_out, addr_out, busy, done, timeout_err
  );

  // Serializer side.
  modport slave (
    input  req_valid, req_mode, req_len, req_addr, burst_stop,
    output req_ready, burst_en, mode_sel, burst_len_out, addr_out, busy, done, timeout_err
  );

endinterface

// File: rtl/piso_msb.sv
// Parallel-in serial-out shift register, MSB first; zeros fill in behind the data.
module piso_msb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg_q;

  // Load has priority over shift; the line returns to 0 once all bits are out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift) begin
      sreg_q <= sreg_q << 1;
    end
  end

  assign sout = sreg_q[WIDTH-1];

endmodule

// File: rtl/burst_req_tx.sv
// Burst request serializer: latches one request, shifts length then address out,
// holds the enable until end of burst or watchdog expiry.
module burst_req_tx
  import burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst,
  burst_req_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(max_u(ADDR_WIDTH, LEN_WIDTH) + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [WD_W-1:0]       wdog_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_din;
  logic                  accept;
  logic                  addr_load;
  logic                  len_shift;
  logic                  addr_shift;
  logic                  ready_d;
  logic                  busy_d;
  logic                  en_d;
  logic                  done_d;
  logic                  err_d;

  // Next state, load/shift strobes and next values of the registered status outputs.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    addr_load  = 1'b0;
    len_shift  = 1'b0;
    addr_shift = 1'b0;
    len_din    = bus.req_mode ? bus.req_len : '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = SEND_LEN;
        end
      end
      SEND_LEN: begin
        len_shift = 1'b1;
        if (bit_cnt_q == CNT_W'(LEN_WIDTH - 1)) begin
          addr_load = 1'b1;
          state_d   = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        addr_shift = 1'b1;
        if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.burst_stop) begin
          state_d = DONE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    en_d    = (state_d == SEND_LEN) || (state_d == SEND_ADDR) || (state_d == ACTIVE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ABORT);
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.burst_en    <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus.req_ready   <= ready_d;
      bus.busy        <= busy_d;
      bus.burst_en    <= en_d;
      bus.done        <= done_d;
      bus.timeout_err <= err_d;
    end
  end

  // Bit counter: counts cycles within a serial phase, restarts on every phase change.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else if ((state_q == SEND_LEN || state_q == SEND_ADDR) && state_d == state_q) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end else begin
      bit_cnt_q <= '0;
    end
  end

  // Watchdog: counts ACTIVE cycles from 0, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q == ACTIVE && state_d == ACTIVE) begin
      if (wdog_q != WD_W'(TIMEOUT)) begin
        wdog_q <= wdog_q + WD_W'(1);
      end
    end else begin
      wdog_q <= '0;
    end
  end

  // Request fields: address held until its phase, mode held until back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      bus.mode_sel <= 1'b0;
    end else if (accept) begin
      addr_q       <= bus.req_addr;
      bus.mode_sel <= bus.req_mode;
    end else if (state_d == IDLE) begin
      bus.mode_sel <= 1'b0;
    end
  end

  // Length loads on accept so its MSB is on the line in the first SEND_LEN cycle.
  piso_msb #(
    .WIDTH (LEN_WIDTH)
  ) u_len_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (len_shift),
    .din   (len_din),
    .sout  (bus.burst_len_out)
  );

  // Address loads at the end of SEND_LEN so the line stays 0 during the length phase.
  piso_msb #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (addr_load),
    .shift (addr_shift),
    .din   (addr_q),
    .sout  (bus.addr_out)
  );

endmodule
